// File: rtl/seq_mon_pkg.sv
// Shared definitions for the sequence monitor.
//   seq_mon_state_t : monitor FSM states (IDLE, SYNC, LOCKED)
//   DEF_*           : default parameter values used by seq_monitor
package seq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } seq_mon_state_t;

    localparam int DEF_WIDTH    = 2;
    localparam int DEF_ERR_W    = 8;
    localparam int DEF_LOCK_CNT = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : asynchronous active-high reset, count -> 0
//   clr   : synchronous clear, count -> 0 (wins over inc)
//   inc   : add one unless already at all-ones
//   count : current value, holds at 2^WIDTH-1
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_monitor.sv
// Receive-side checker for a modulo-2^WIDTH incrementing stream.
//   clk        : clock
//   rst        : asynchronous active-high reset
//   clr        : synchronous clear (FSM -> IDLE, error count -> 0)
//   in_valid   : in_data is sampled this cycle
//   in_data    : sequence word under test
//   locked     : high while the FSM is in LOCKED
//   err_pulse  : one-cycle pulse per sequence break seen while locked
//   wrap_pulse : one-cycle pulse on an accepted max->0 step while locked
//   err_count  : saturating count of errors since reset or clr
// All outputs are registered; a sample taken on edge N is reflected after edge N.
module seq_monitor
    import seq_mon_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    // match runs 0..LOCK_CNT, so it needs enough bits to hold LOCK_CNT itself.
    localparam int                   MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0]   LOCK_TGT = MATCH_W'(LOCK_CNT);

    seq_mon_state_t     state_q,      state_d;
    logic [WIDTH-1:0]   prev_q,       prev_d;
    logic [MATCH_W-1:0] match_q,      match_d;
    logic               locked_q,     locked_d;
    logic               err_pulse_q,  err_pulse_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic               err_inc;

    logic [WIDTH-1:0]   expected;
    logic               correct;

    // Natural WIDTH-bit wrap gives the modulo-2^WIDTH successor for free.
    assign expected = prev_q + WIDTH'(1);
    assign correct  = (in_data == expected);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        prev_d       = prev_q;
        match_d      = match_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        err_inc      = 1'b0;

        if (clr) begin
            // The sample in this cycle, if any, is discarded.
            state_d = IDLE;
            match_d = '0;
        end else if (in_valid) begin
            prev_d = in_data;
            unique case (state_q)
                IDLE: begin
                    match_d = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (correct) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        // Pre-lock mismatches only restart the streak.
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (correct) begin
                        wrap_pulse_d = (prev_q == '1);
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        match_d     = '0;
                        state_d     = SYNC;
                    end
                end
                default: begin
                    state_d = IDLE;
                    match_d = '0;
                end
            endcase
        end

        // Registered so locked moves on the same edge as the pulses.
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            prev_q       <= prev_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (err_inc),
        .count (err_count)
    );

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor. Two instances share the stimulus:
// u_dut_a uses the default 8-bit error counter, u_dut_b a 2-bit one so
// saturation is reachable. A behavioural model tracks the expected outputs.
module tb_seq_monitor;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [1:0] in_data;

    logic       locked_a, err_pulse_a, wrap_pulse_a;
    logic [7:0] err_count_a;
    logic       locked_b, err_pulse_b, wrap_pulse_b;
    logic [1:0] err_count_b;

    seq_monitor #(.WIDTH(2), .ERR_W(8), .LOCK_CNT(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked_a),
        .err_pulse  (err_pulse_a),
        .wrap_pulse (wrap_pulse_a),
        .err_count  (err_count_a)
    );

    seq_monitor #(.WIDTH(2), .ERR_W(2), .LOCK_CNT(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked_b),
        .err_pulse  (err_pulse_b),
        .wrap_pulse (wrap_pulse_b),
        .err_count  (err_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int m_has_ref, m_prev, m_streak, m_locked, m_errs, m_err, m_wrap;
    int seen_err, seen_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_has_ref = 0; m_prev = 0; m_streak = 0; m_locked = 0;
        m_errs = 0; m_err = 0; m_wrap = 0;
    endtask

    // One sample against the stream rules: capture, count a streak of
    // correct increments up to 2, then flag any break while locked.
    task automatic model_step(input int v, input int d, input int c);
        m_err  = 0;
        m_wrap = 0;
        if (c != 0) begin
            m_has_ref = 0; m_streak = 0; m_locked = 0; m_errs = 0;
        end else if (v != 0) begin
            if (m_has_ref == 0) begin
                m_has_ref = 1; m_streak = 0; m_locked = 0;
            end else if (m_locked != 0) begin
                if (d == (m_prev + 1) % 4) begin
                    m_wrap = (m_prev == 3) ? 1 : 0;
                end else begin
                    m_err = 1; m_errs++; m_locked = 0; m_streak = 0;
                end
            end else if (d == (m_prev + 1) % 4) begin
                m_streak++;
                if (m_streak >= 2) m_locked = 1;
            end else begin
                m_streak = 0;
            end
            m_prev = d;
        end
    endtask

    task automatic step(input int v, input int d, input int c);
        in_valid = 1'(v);
        in_data  = 2'(d);
        clr      = 1'(c);
        @(posedge clk);
        #1;
        model_step(v, d, c);
        check("locked_a",     32'(locked_a),     32'(m_locked));
        check("err_pulse_a",  32'(err_pulse_a),  32'(m_err));
        check("wrap_pulse_a", 32'(wrap_pulse_a), 32'(m_wrap));
        check("err_count_a",  32'(err_count_a),  32'((m_errs > 255) ? 255 : m_errs));
        check("locked_b",     32'(locked_b),     32'(m_locked));
        check("err_pulse_b",  32'(err_pulse_b),  32'(m_err));
        check("wrap_pulse_b", 32'(wrap_pulse_b), 32'(m_wrap));
        check("err_count_b",  32'(err_count_b),  32'((m_errs > 3) ? 3 : m_errs));
        if (err_pulse_a)  seen_err++;
        if (wrap_pulse_a) seen_wrap++;
    endtask

    initial begin
        int d;
        model_reset();
        seen_err = 0; seen_wrap = 0;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        check("reset_locked",    32'(locked_a),     32'd0);
        check("reset_err_pulse", 32'(err_pulse_a),  32'd0);
        check("reset_wrap",      32'(wrap_pulse_a), 32'd0);
        check("reset_err_count", 32'(err_count_a),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lock on 0,1,2 and wrap once after 3 -> 0.
        seen_wrap = 0;
        step(1, 0, 0); step(1, 1, 0);
        step(1, 2, 0);
        check("lock_after_3rd", 32'(locked_a), 32'd1);
        step(1, 3, 0); step(1, 0, 0); step(1, 1, 0);
        check("one_wrap", 32'(seen_wrap), 32'd1);

        // Locked 2,3,0 then a break on 2, then relock on 3,0,1.
        step(1, 2, 0); step(1, 3, 0); step(1, 0, 0);
        step(1, 2, 0);
        check("break_err_pulse", 32'(err_pulse_a), 32'd1);
        check("break_unlocked",  32'(locked_a),     32'd0);
        check("break_count",     32'(err_count_a),  32'd1);
        step(1, 3, 0); step(1, 0, 0); step(1, 1, 0);
        check("relocked", 32'(locked_a), 32'd1);

        // Clear, then pre-lock mismatches never count as errors.
        step(0, 0, 1);
        seen_err = 0;
        step(1, 0, 0); step(1, 2, 0); step(1, 3, 0); step(1, 1, 0);
        check("prelock_no_err",    32'(seen_err),    32'd0);
        check("prelock_no_lock",   32'(locked_a),    32'd0);
        check("prelock_count_zero", 32'(err_count_a), 32'd0);

        // Lock, then alternate valid and invalid cycles with junk data.
        step(1, 2, 0); step(1, 3, 0);
        d = 3;
        seen_err = 0;
        for (int i = 0; i < 16; i++) begin
            d = (d + 1) % 4;
            step(1, d, 0);
            step(0, int'($urandom_range(0, 3)), 0);
        end
        check("gap_no_err",  32'(seen_err), 32'd0);
        check("gap_locked",  32'(locked_a), 32'd1);

        // Five breaks, each followed by a relock; the 2-bit count saturates.
        seen_err = 0;
        for (int i = 0; i < 5; i++) begin
            d = (d + 2) % 4;
            step(1, d, 0);
            d = (d + 1) % 4; step(1, d, 0);
            d = (d + 1) % 4; step(1, d, 0);
        end
        check("five_err_pulses", 32'(seen_err),    32'd5);
        check("sat_count_b",     32'(err_count_b), 32'd3);
        check("count_a_five",    32'(err_count_a), 32'd5);

        // Asynchronous reset between edges while locked with a non-zero count.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_locked", 32'(locked_a),    32'd0);
        check("async_rst_count",  32'(err_count_a), 32'd0);
        check("async_rst_count_b", 32'(err_count_b), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        step(1, 1, 0); step(1, 2, 0);
        check("relock_not_yet", 32'(locked_a), 32'd0);
        step(1, 3, 0);
        check("relock_after_3", 32'(locked_a), 32'd1);

        // Get a non-zero count, then clr with a valid sample that must be ignored.
        step(1, 1, 0);
        step(1, 2, 0); step(1, 3, 0);
        step(1, 1, 1);
        check("clr_count",  32'(err_count_a), 32'd0);
        check("clr_locked", 32'(locked_a),    32'd0);
        // If the sample 1 had been taken, 2 and 3 would complete a lock.
        step(1, 2, 0); step(1, 3, 0);
        check("clr_sample_dropped", 32'(locked_a), 32'd0);

        // Random traffic: mostly correct increments with breaks, gaps, clears.
        for (int i = 0; i < 300; i++) begin
            int v, c, dd;
            v  = ($urandom_range(0, 99) < 85) ? 1 : 0;
            c  = ($urandom_range(0, 99) < 3)  ? 1 : 0;
            dd = ($urandom_range(0, 99) < 80) ? (m_prev + 1) % 4 : int'($urandom_range(0, 3));
            step(v, dd, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
